operand_fetch_stage: RTL and testbench

Operand-fetch stage between decode and execute in the Simple RISC pipeline. It accepts one decoded instruction per cycle, drives the register file read addresses, and tracks registers with an in-flight write in a 16-entry scoreboard. It stalls on RAW/WAW hazards and bypasses the same-cycle writeback value. Operands and control are registered toward execute behind a valid/ready handshake.

---
 rtl/operand_fetch_stage_pkg.sv | 14 +
 rtl/operand_fetch_stage_scoreboard.sv | 30 +++
 rtl/operand_fetch_stage.sv | 109 ++++++++++
 tb/tb_operand_fetch_stage.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/operand_fetch_stage_pkg.sv
// Shared sizing constants and helpers for the operand-fetch stage.
package operand_fetch_stage_pkg;
  localparam int REG_W       = 32;
  localparam int REG_IDX_W   = 4;
  localparam int NUM_REGS    = 16;
  localparam int STALL_CNT_W = 16;

  // True when an enabled register-index port targets idx.
  function automatic logic idx_hit(input logic en,
                                   input logic [REG_IDX_W-1:0] port_idx,
                                   input logic [REG_IDX_W-1:0] idx);
    return en && (port_idx == idx);
  endfunction
endpackage

// File: rtl/operand_fetch_stage_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set has priority over both clears.
module operand_fetch_stage_scoreboard
  import operand_fetch_stage_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 set_en,
  input  logic [REG_IDX_W-1:0] set_idx,
  input  logic                 clr_en,
  input  logic [REG_IDX_W-1:0] clr_idx,
  input  logic                 fclr_en,
  input  logic [REG_IDX_W-1:0] fclr_idx,
  output logic [NUM_REGS-1:0]  busy
);
  logic [NUM_REGS-1:0] busy_q, busy_d;

  always_comb begin
    busy_d = busy_q;
    if (clr_en)  busy_d[clr_idx]  = 1'b0;
    if (fclr_en) busy_d[fclr_idx] = 1'b0;
    if (set_en)  busy_d[set_idx]  = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) busy_q <= '0;
    else          busy_q <= busy_d;
  end

  assign busy = busy_q;
endmodule

// File: rtl/operand_fetch_stage.sv
// Operand fetch: hazard detection against the scoreboard, writeback bypass,
// and a single valid/ready output register toward execute.
module operand_fetch_stage
  import operand_fetch_stage_pkg::*;
#(
  parameter int CTRL_W = 8
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [REG_IDX_W-1:0]   in_rs1,
  input  logic [REG_IDX_W-1:0]   in_rs2,
  input  logic [REG_IDX_W-1:0]   in_rd,
  input  logic                   in_wr_en,
  input  logic                   in_use_imm,
  input  logic [REG_W-1:0]       in_imm,
  input  logic [CTRL_W-1:0]      in_ctrl,
  output logic [REG_IDX_W-1:0]   RA,
  output logic [REG_IDX_W-1:0]   RB,
  input  logic [REG_W-1:0]       BusA,
  input  logic [REG_W-1:0]       BusB,
  input  logic                   wb_en,
  input  logic [REG_IDX_W-1:0]   wb_rd,
  input  logic [REG_W-1:0]       wb_data,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [REG_W-1:0]       out_a,
  output logic [REG_W-1:0]       out_b,
  output logic [REG_IDX_W-1:0]   out_rd,
  output logic                   out_wr_en,
  output logic [CTRL_W-1:0]      out_ctrl,
  output logic [STALL_CNT_W-1:0] stall_cycles
);
  logic [NUM_REGS-1:0]    busy;
  logic                   hit1, hit2, hitd, raw, waw, hazard, issue, fclr_en;
  logic [REG_W-1:0]       op_a, op_b;
  logic                   out_valid_q;
  logic [REG_W-1:0]       out_a_q, out_b_q;
  logic [REG_IDX_W-1:0]   out_rd_q;
  logic                   out_wr_en_q;
  logic [CTRL_W-1:0]      out_ctrl_q;
  logic [STALL_CNT_W-1:0] stall_q;

  assign RA = in_rs1;
  assign RB = in_rs2;

  // A same-cycle writeback to a busy source satisfies it through the bypass.
  always_comb begin
    hit1     = idx_hit(wb_en, wb_rd, in_rs1);
    hit2     = idx_hit(wb_en, wb_rd, in_rs2);
    hitd     = idx_hit(wb_en, wb_rd, in_rd);
    raw      = (busy[in_rs1] && !hit1) || (!in_use_imm && busy[in_rs2] && !hit2);
    waw      = in_wr_en && busy[in_rd] && !hitd;
    hazard   = in_valid && (raw || waw);
    in_ready = (!out_valid_q || out_ready) && !hazard && !flush;
    issue    = in_valid && in_ready;
    op_a     = hit1 ? wb_data : BusA;
    op_b     = in_use_imm ? in_imm : (hit2 ? wb_data : BusB);
  end

  assign fclr_en = flush && out_valid_q && out_wr_en_q;

  operand_fetch_stage_scoreboard u_sb (
    .clock    (clock),
    .reset_n  (reset_n),
    .set_en   (issue && in_wr_en),
    .set_idx  (in_rd),
    .clr_en   (wb_en),
    .clr_idx  (wb_rd),
    .fclr_en  (fclr_en),
    .fclr_idx (out_rd_q),
    .busy     (busy)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q <= 1'b0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      out_rd_q    <= '0;
      out_wr_en_q <= 1'b0;
      out_ctrl_q  <= '0;
    end else if (issue) begin
      out_valid_q <= 1'b1;
      out_a_q     <= op_a;
      out_b_q     <= op_b;
      out_rd_q    <= in_rd;
      out_wr_en_q <= in_wr_en;
      out_ctrl_q  <= in_ctrl;
    end else if (flush || out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                   stall_q <= '0;
    else if (hazard && stall_q != '1) stall_q <= stall_q + 1'b1;
  end

  assign out_valid    = out_valid_q;
  assign out_a        = out_a_q;
  assign out_b        = out_b_q;
  assign out_rd       = out_rd_q;
  assign out_wr_en    = out_wr_en_q;
  assign out_ctrl     = out_ctrl_q;
  assign stall_cycles = stall_q;
endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed scenarios plus a randomized run against a rule-level reference model.
module tb_operand_fetch_stage;
  import operand_fetch_stage_pkg::*;
  localparam int CTRL_W = 8;

  logic        clock = 1'b0, reset_n = 1'b0;
  logic        in_valid, in_ready, in_wr_en, in_use_imm;
  logic [3:0]  in_rs1, in_rs2, in_rd, RA, RB, wb_rd, out_rd;
  logic [31:0] in_imm, BusA, BusB, wb_data, out_a, out_b;
  logic [7:0]  in_ctrl, out_ctrl;
  logic        wb_en, flush, out_valid, out_ready, out_wr_en;
  logic [15:0] stall_cycles;
  logic [31:0] rf [16];

  int errors = 0, checks = 0, exp_stall = 0;

  operand_fetch_stage #(.CTRL_W(CTRL_W)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_wr_en(in_wr_en),
    .in_use_imm(in_use_imm), .in_imm(in_imm), .in_ctrl(in_ctrl), .RA(RA), .RB(RB),
    .BusA(BusA), .BusB(BusB), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a),
    .out_b(out_b), .out_rd(out_rd), .out_wr_en(out_wr_en), .out_ctrl(out_ctrl),
    .stall_cycles(stall_cycles)
  );

  always #5 clock = ~clock;

  // Register file owned by the bench: combinational read, write at the edge.
  assign BusA = rf[RA];
  assign BusB = rf[RB];
  always @(posedge clock) if (wb_en) rf[wb_rd] <= wb_data;

  task automatic step();
    @(posedge clock); #1;
  endtask

  task automatic drive_in(input logic v, input logic [3:0] rs1, rs2, rd,
                          input logic wr, imm_sel, input logic [31:0] imm,
                          input logic [7:0] ctrl);
    in_valid = v; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
    in_wr_en = wr; in_use_imm = imm_sel; in_imm = imm; in_ctrl = ctrl;
  endtask

  task automatic test_reset();
    drive_in(0, 0, 0, 0, 0, 0, 0, 0);
    wb_en = 0; wb_rd = 0; wb_data = 0; flush = 0; out_ready = 1;
    reset_n = 0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++; if (out_a !== 32'd0 || out_b !== 32'd0 || out_rd !== 4'd0 || out_ctrl !== 8'd0 || out_wr_en !== 1'b0)
      begin errors++; $display("FAIL reset_out_fields got a=%0h b=%0h rd=%0d ctrl=%0h wr=%0b exp=0", out_a, out_b, out_rd, out_ctrl, out_wr_en); end
    checks++; if (stall_cycles !== 16'd0) begin errors++; $display("FAIL reset_stall got=%0d exp=0", stall_cycles); end
    checks++; if (dut.busy !== 16'h0) begin errors++; $display("FAIL reset_busy got=%h exp=0000", dut.busy); end
    step(); step();
    reset_n = 1;
    exp_stall = 0;
  endtask

  task automatic test_basic_issue();
    drive_in(1, 1, 2, 3, 1, 0, 0, 8'hA5);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready got=%0b exp=1", in_ready); end
    checks++; if (RA !== 4'd1 || RB !== 4'd2) begin errors++; $display("FAIL basic_raddr got=%0d/%0d exp=1/2", RA, RB); end
    step();
    drive_in(0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (out_valid !== 1'b1 || out_a !== 32'd16 || out_b !== 32'd32)
      begin errors++; $display("FAIL basic_out got v=%0b a=%0d b=%0d exp v=1 a=16 b=32", out_valid, out_a, out_b); end
    checks++; if (out_rd !== 4'd3 || out_wr_en !== 1'b1 || out_ctrl !== 8'hA5)
      begin errors++; $display("FAIL basic_fields got rd=%0d wr=%0b ctrl=%0h exp 3/1/a5", out_rd, out_wr_en, out_ctrl); end
    checks++; if (dut.busy !== 16'h0008) begin errors++; $display("FAIL basic_busy got=%h exp=0008", dut.busy); end
  endtask

  task automatic test_raw_stall();
    drive_in(1, 3, 0, 6, 1, 1, 32'd7, 8'h42);
    for (int k = 1; k <= 3; k++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL raw_in_ready cyc=%0d got=%0b exp=0", k, in_ready); end
      step();
      exp_stall++;
      checks++; if (stall_cycles !== 16'(exp_stall)) begin errors++; $display("FAIL raw_stall_cnt got=%0d exp=%0d", stall_cycles, exp_stall); end
    end
    wb_en = 1; wb_rd = 3; wb_data = 32'd48;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL raw_bypass_ready got=%0b exp=1", in_ready); end
    step();
    wb_en = 0;
    drive_in(0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (out_valid !== 1'b1 || out_a !== 32'd48 || out_b !== 32'd7 || out_rd !== 4'd6)
      begin errors++; $display("FAIL raw_bypass_out got v=%0b a=%0d b=%0d rd=%0d exp 1/48/7/6", out_valid, out_a, out_b, out_rd); end
    checks++; if (dut.busy !== 16'h0040 || stall_cycles !== 16'(exp_stall))
      begin errors++; $display("FAIL raw_after got busy=%h stall=%0d exp busy=0040 stall=%0d", dut.busy, stall_cycles, exp_stall); end
  endtask

  task automatic test_waw_set_wins();
    drive_in(1, 0, 0, 4, 1, 0, 0, 8'h01);
    step();
    drive_in(1, 1, 2, 4, 1, 0, 0, 8'h02);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL waw_in_ready got=%0b exp=0", in_ready); end
    step();
    exp_stall++;
    checks++; if (stall_cycles !== 16'(exp_stall) || dut.busy !== 16'h0050)
      begin errors++; $display("FAIL waw_stall got stall=%0d busy=%h exp stall=%0d busy=0050", stall_cycles, dut.busy, exp_stall); end
    wb_en = 1; wb_rd = 4; wb_data = 32'd99;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL waw_wb_ready got=%0b exp=1", in_ready); end
    step();
    drive_in(0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (dut.busy !== 16'h0050 || out_rd !== 4'd4 || out_a !== 32'd16 || out_ctrl !== 8'h02)
      begin errors++; $display("FAIL waw_set_wins got busy=%h rd=%0d a=%0d ctrl=%0h exp 0050/4/16/02", dut.busy, out_rd, out_a, out_ctrl); end
    step();
    wb_rd = 6; step();
    wb_en = 0;
    checks++; if (dut.busy !== 16'h0 || stall_cycles !== 16'(exp_stall))
      begin errors++; $display("FAIL waw_cleanup got busy=%h stall=%0d exp 0000/%0d", dut.busy, stall_cycles, exp_stall); end
  endtask

  task automatic test_back_pressure();
    drive_in(1, 1, 2, 7, 1, 0, 0, 8'h3C);
    step();
    out_ready = 0;
    drive_in(1, 2, 1, 8, 1, 0, 0, 8'h11);
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc=%0d got=%0b exp=0", k, in_ready); end
      step();
      checks++; if (out_valid !== 1'b1 || out_a !== 32'd16 || out_b !== 32'd32 || out_rd !== 4'd7 || out_ctrl !== 8'h3C)
        begin errors++; $display("FAIL bp_hold cyc=%0d got v=%0b a=%0d b=%0d rd=%0d ctrl=%0h", k, out_valid, out_a, out_b, out_rd, out_ctrl); end
    end
    out_ready = 1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got=%0b exp=1", in_ready); end
    step();
    drive_in(0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (out_a !== 32'd32 || out_b !== 32'd16 || out_rd !== 4'd8 || out_ctrl !== 8'h11 || dut.busy !== 16'h0180)
      begin errors++; $display("FAIL bp_release got a=%0d b=%0d rd=%0d ctrl=%0h busy=%h", out_a, out_b, out_rd, out_ctrl, dut.busy); end
    checks++; if (stall_cycles !== 16'(exp_stall)) begin errors++; $display("FAIL bp_no_stall got=%0d exp=%0d", stall_cycles, exp_stall); end
    wb_en = 1; wb_rd = 7; wb_data = 32'd5; step();
    wb_rd = 8; step();
    wb_en = 0;
  endtask

  task automatic test_flush();
    out_ready = 0;
    drive_in(1, 1, 2, 5, 1, 0, 0, 8'h55);
    step();
    checks++; if (out_valid !== 1'b1 || dut.busy !== 16'h0020)
      begin errors++; $display("FAIL flush_setup got v=%0b busy=%h exp 1/0020", out_valid, dut.busy); end
    drive_in(1, 1, 2, 9, 1, 0, 0, 8'h66);
    flush = 1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got=%0b exp=0", in_ready); end
    step();
    flush = 0;
    drive_in(0, 0, 0, 0, 0, 0, 0, 0);
    checks++; if (out_valid !== 1'b0 || dut.busy !== 16'h0)
      begin errors++; $display("FAIL flush_result got v=%0b busy=%h exp 0/0000", out_valid, dut.busy); end
    out_ready = 1;
  endtask

  task automatic test_reset_mid_stall();
    drive_in(1, 1, 2, 3, 1, 0, 0, 8'h03); step();
    drive_in(1, 1, 2, 4, 1, 0, 0, 8'h04); step();
    out_ready = 0;
    drive_in(1, 3, 0, 10, 1, 1, 32'd1, 8'h0A);
    step(); step(); step();
    exp_stall += 3;
    checks++; if (dut.busy !== 16'h0018 || stall_cycles !== 16'd7 || exp_stall != 7)
      begin errors++; $display("FAIL rms_setup got busy=%h stall=%0d exp 0018/7", dut.busy, stall_cycles); end
    #2 reset_n = 0;
    #1;
    checks++; if (dut.busy !== 16'h0 || stall_cycles !== 16'd0 || out_valid !== 1'b0 || out_a !== 32'd0)
      begin errors++; $display("FAIL rms_reset got busy=%h stall=%0d v=%0b a=%0h exp all 0", dut.busy, stall_cycles, out_valid, out_a); end
    drive_in(0, 0, 0, 0, 0, 0, 0, 0);
    out_ready = 1;
    step();
    reset_n = 1;
    exp_stall = 0;
  endtask

  // Reference model: spec rules applied to plain bench-side state.
  task automatic test_random();
    logic [15:0] mb = '0;
    logic        mv = 0, mwr = 0, hold = 0;
    logic [31:0] ma = 0, mbv = 0;
    logic [3:0]  mrd = 0;
    logic [7:0]  mctrl = 0;
    int          mstall = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      logic h1, h2, hd, hz, rdy, iss;
      logic [31:0] opa, opb;
      if (!hold)
        drive_in(($urandom_range(0, 9) < 7), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom, 8'($urandom_range(0, 255)));
      wb_en = 1'($urandom_range(0, 1));
      wb_rd = 4'($urandom_range(0, 15));
      if (mb != 0 && $urandom_range(0, 3) != 0)
        while (!mb[wb_rd]) wb_rd = 4'($urandom_range(0, 15));
      wb_data = $urandom;
      out_ready = ($urandom_range(0, 9) < 7);
      flush = ($urandom_range(0, 19) == 0);
      #1;
      h1  = wb_en && wb_rd == in_rs1;
      h2  = wb_en && wb_rd == in_rs2;
      hd  = wb_en && wb_rd == in_rd;
      hz  = in_valid && ((mb[in_rs1] && !h1) || (!in_use_imm && mb[in_rs2] && !h2) ||
                         (in_wr_en && mb[in_rd] && !hd));
      rdy = (!mv || out_ready) && !hz && !flush;
      iss = in_valid && rdy;
      opa = h1 ? wb_data : rf[in_rs1];
      opb = in_use_imm ? in_imm : (h2 ? wb_data : rf[in_rs2]);
      checks++; if (in_ready !== rdy) begin errors++; $display("FAIL rand_in_ready cyc=%0d got=%0b exp=%0b", cyc, in_ready, rdy); end
      if (wb_en) mb[wb_rd] = 1'b0;
      if (flush && mv && mwr) mb[mrd] = 1'b0;
      if (iss && in_wr_en) mb[in_rd] = 1'b1;
      if (iss) begin
        mv = 1; ma = opa; mbv = opb; mrd = in_rd; mwr = in_wr_en; mctrl = in_ctrl;
      end else if (flush || out_ready) mv = 0;
      if (hz && mstall != 65535) mstall++;
      hold = in_valid && !rdy;
      step();
      checks++; if (out_valid !== mv || dut.busy !== mb || stall_cycles !== 16'(mstall))
        begin errors++; $display("FAIL rand_state cyc=%0d got v=%0b busy=%h stall=%0d exp v=%0b busy=%h stall=%0d",
                                 cyc, out_valid, dut.busy, stall_cycles, mv, mb, mstall); end
      if (mv) begin
        checks++; if (out_a !== ma || out_b !== mbv || out_rd !== mrd || out_wr_en !== mwr || out_ctrl !== mctrl)
          begin errors++; $display("FAIL rand_out cyc=%0d got a=%h b=%h rd=%0d wr=%0b ctrl=%h exp a=%h b=%h rd=%0d wr=%0b ctrl=%h",
                                   cyc, out_a, out_b, out_rd, out_wr_en, out_ctrl, ma, mbv, mrd, mwr, mctrl); end
      end
    end
    drive_in(0, 0, 0, 0, 0, 0, 0, 0);
    wb_en = 0; flush = 0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rf[i] = 32'h1000 + i;
    rf[1] = 32'd16;
    rf[2] = 32'd32;
    test_reset();
    test_basic_issue();
    test_raw_stall();
    test_waw_set_wins();
    test_back_pressure();
    test_flush();
    test_reset_mid_stall();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
